sdspi_master: RTL and testbench

SDSPI_MASTER -- requirements
Module: sdspi_master

---
 rtl/sdspi_master_if.sv | 23 ++
 rtl/sdspi_master.sv | 133 +++++++++++++
 tb/tb_sdspi_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sdspi_master_if.sv
// Host/card signal bundle for the SD-card SPI master.
// master modport is the controller view; slave modport is the host+card side.
interface sdspi_master_if;
  logic [2:0] spiOP;
  logic [7:0] spiTXD;
  logic [7:0] spiRXD;
  logic       spiDONE;
  logic       spiBUSY;
  logic       sdCS;
  logic       sdCLK;
  logic       sdDI;
  logic       sdDO;

  modport master (
    input  spiOP, spiTXD, sdDO,
    output spiRXD, spiDONE, spiBUSY, sdCS, sdCLK, sdDI
  );

  modport slave (
    output spiOP, spiTXD, sdDO,
    input  spiRXD, spiDONE, spiBUSY, sdCS, sdCLK, sdDI
  );
endinterface

// File: rtl/sdspi_master.sv
// SD-card SPI mode-0 byte master: CS/speed ops finish in 2 cycles, TR in 16*DIV+1 cycles.
// No queueing: ops arriving while busy or on the done cycle are dropped.
module sdspi_master #(
  parameter int unsigned SLOW_DIV = 100,
  parameter int unsigned FAST_DIV = 2
) (
  input logic           clk,
  input logic           reset,
  sdspi_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, CMD, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] OP_CSL  = 3'd1;
  localparam logic [2:0] OP_CSH  = 3'd2;
  localparam logic [2:0] OP_FAST = 3'd3;
  localparam logic [2:0] OP_SLOW = 3'd4;
  localparam logic [2:0] OP_TR   = 3'd5;

  localparam logic [7:0] SLOW_DIV8 = SLOW_DIV[7:0];
  localparam logic [7:0] FAST_DIV8 = FAST_DIV[7:0];

  state_t     state_q;
  logic [7:0] div_q;
  logic [7:0] cnt_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic [7:0] rxd_q;
  logic [2:0] bit_q;
  logic       fast_q;
  logic       cs_q;
  logic       sclk_q;
  logic       di_q;
  logic       done_q;
  logic       busy_q;

  logic [7:0] div_d;
  logic       op_ok;
  logic       accept;

  assign div_d  = fast_q ? FAST_DIV8 : SLOW_DIV8;
  assign op_ok  = (bus.spiOP >= OP_CSL) && (bus.spiOP <= OP_TR);
  assign accept = !busy_q && !done_q && op_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 8'h00;
      cnt_q   <= 8'h00;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rxd_q   <= 8'h00;
      bit_q   <= 3'd0;
      fast_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      di_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q  <= 1'b1;
            state_q <= CMD;
            case (bus.spiOP)
              OP_CSL:  cs_q   <= 1'b0;
              OP_CSH:  cs_q   <= 1'b1;
              OP_FAST: fast_q <= 1'b1;
              OP_SLOW: fast_q <= 1'b0;
              default: begin
                // TR: divider is frozen here so a later speed op cannot skew this byte
                tx_q    <= bus.spiTXD;
                di_q    <= bus.spiTXD[7];
                div_q   <= div_d;
                cnt_q   <= div_d;
                bit_q   <= 3'd0;
                state_q <= LOW;
              end
            endcase
          end
        end
        CMD: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        LOW: begin
          if (cnt_q == 8'd1) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[6:0], bus.sdDO};
            cnt_q   <= div_q;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        HIGH: begin
          if (cnt_q == 8'd1) begin
            sclk_q <= 1'b0;
            cnt_q  <= div_q;
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              rxd_q   <= rx_q;
              di_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              tx_q    <= {tx_q[6:0], 1'b0};
              di_q    <= tx_q[6];
              state_q <= LOW;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spiRXD  = rxd_q;
  assign bus.spiDONE = done_q;
  assign bus.spiBUSY = busy_q;
  assign bus.sdCS    = cs_q;
  assign bus.sdCLK   = sclk_q;
  assign bus.sdDI    = di_q;

endmodule

// File: tb/tb_sdspi_master.sv
// Vector table plus reset/injection sequences for sdspi_master with a mode-0 card model.
module tb_sdspi_master;

  localparam logic [2:0] NOP = 3'd0, CSL = 3'd1, CSH = 3'd2, FAST = 3'd3, SLOW = 3'd4, TR = 3'd5;

  typedef struct {
    logic [2:0] op;
    logic [7:0] txd;
    logic [7:0] card;
    bit         inject;
    bit         exp_done;
    int         exp_lat;
    logic       exp_cs;
    logic [7:0] exp_rxd;
    int         exp_pulses;
    int         exp_hi;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];

  sdspi_master_if bus ();

  sdspi_master #(.SLOW_DIV(100), .FAST_DIV(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] txd, input logic [7:0] card,
                              input bit inject, input bit exp_done, input int exp_lat,
                              input logic exp_cs, input logic [7:0] exp_rxd,
                              input int exp_pulses, input int exp_hi);
    vec_t v;
    v.op = op; v.txd = txd; v.card = card; v.inject = inject; v.exp_done = exp_done;
    v.exp_lat = exp_lat; v.exp_cs = exp_cs; v.exp_rxd = exp_rxd;
    v.exp_pulses = exp_pulses; v.exp_hi = exp_hi;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t       e;
    int         lat = 0, rises = 0, hi_run = 0, hi_max = 0, extra = 0, budget;
    logic [7:0] mosi = 8'h00;
    bit         seen = 0, busy_all = 1, busy_any = 0;
    logic       prev = 1'b0;
    budget = v.exp_done ? v.exp_lat + 20 : 6;
    sb.push_back(v);
    @(posedge clk); #1;
    bus.spiTXD = v.txd;
    bus.spiOP  = v.op;
    bus.sdDO   = v.card[7];
    @(posedge clk); #1;
    bus.spiOP  = NOP;
    bus.spiTXD = 8'h00;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (bus.sdCLK && !prev) begin
        mosi = {mosi[6:0], bus.sdDI};
        rises++;
      end
      if (bus.sdCLK) hi_run++;
      else begin
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      prev = bus.sdCLK;
      if (rises < 8) bus.sdDO = v.card[3'(7 - rises)];
      else bus.sdDO = 1'b1;
      if (bus.spiBUSY) busy_any = 1; else busy_all = 0;
      if (v.inject && cyc >= 10 && cyc <= 11) bus.spiOP = CSH;
      else if (v.inject && cyc == 12) bus.spiOP = TR;
      else bus.spiOP = NOP;
      if (bus.spiDONE) begin
        lat  = cyc;
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.spiOP = NOP;
    e = sb.pop_front();
    chk("done_seen", int'(seen), int'(e.exp_done));
    if (e.exp_done) begin
      chk("done_latency", lat, e.exp_lat);
      chk("busy_through_done", int'(busy_all), 1);
    end else begin
      chk("busy_on_ignored_op", int'(busy_any), 0);
    end
    chk("sdcs", int'(bus.sdCS), int'(e.exp_cs));
    chk("sdclk_pulses", rises, e.exp_pulses);
    if (e.exp_pulses == 8) begin
      chk("mosi_bits", int'(mosi), int'(e.txd));
      chk("high_phase_len", hi_max, e.exp_hi);
      chk("sddi_idle", int'(bus.sdDI), 1);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.spiDONE) extra++;
    end
    chk("spirxd", int'(bus.spiRXD), int'(e.exp_rxd));
    chk("no_extra_done", extra, 0);
    chk("sdclk_idle", int'(bus.sdCLK), 0);
  endtask

  initial begin
    vec_t tbl[13];
    int   rises, extra;
    bit   got;
    logic prev;

    tbl[0]  = mk(CSL,  8'h00, 8'h00, 0, 1,    2, 1'b0, 8'h00, 0,   0);
    tbl[1]  = mk(CSH,  8'h00, 8'h00, 0, 1,    2, 1'b1, 8'h00, 0,   0);
    tbl[2]  = mk(3'd6, 8'h00, 8'h00, 0, 0,    0, 1'b1, 8'h00, 0,   0);
    tbl[3]  = mk(3'd7, 8'h00, 8'h00, 0, 0,    0, 1'b1, 8'h00, 0,   0);
    tbl[4]  = mk(TR,   8'h5A, 8'hC3, 0, 1, 1601, 1'b1, 8'hC3, 8, 100);
    tbl[5]  = mk(FAST, 8'h00, 8'h00, 0, 1,    2, 1'b1, 8'hC3, 0,   0);
    tbl[6]  = mk(TR,   8'hA5, 8'h3C, 0, 1,   33, 1'b1, 8'h3C, 8,   2);
    tbl[7]  = mk(CSL,  8'h00, 8'h00, 0, 1,    2, 1'b0, 8'h3C, 0,   0);
    tbl[8]  = mk(TR,   8'hFF, 8'h00, 1, 1,   33, 1'b0, 8'h00, 8,   2);
    tbl[9]  = mk(TR,   8'h00, 8'hFF, 0, 1,   33, 1'b0, 8'hFF, 8,   2);
    tbl[10] = mk(TR,   8'h81, 8'h7E, 0, 1,   33, 1'b0, 8'h7E, 8,   2);
    tbl[11] = mk(SLOW, 8'h00, 8'h00, 0, 1,    2, 1'b0, 8'h7E, 0,   0);
    tbl[12] = mk(FAST, 8'h00, 8'h00, 0, 1,    2, 1'b0, 8'h7E, 0,   0);

    // reset with an op held on the bus: the op must not be taken
    reset      = 1'b1;
    bus.spiOP  = CSL;
    bus.spiTXD = 8'h00;
    bus.sdDO   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdcs", int'(bus.sdCS), 1);
    chk("rst_sdclk", int'(bus.sdCLK), 0);
    chk("rst_sddi", int'(bus.sdDI), 1);
    chk("rst_rxd", int'(bus.spiRXD), 0);
    chk("rst_done", int'(bus.spiDONE), 0);
    chk("rst_busy", int'(bus.spiBUSY), 0);
    reset     = 1'b0;
    bus.spiOP = NOP;
    @(posedge clk); #1;
    chk("post_rst_op_ignored_cs", int'(bus.sdCS), 1);
    chk("post_rst_op_ignored_busy", int'(bus.spiBUSY), 0);

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // reset lands mid-transfer right after the 4th sdCLK rise
    @(posedge clk); #1;
    bus.spiTXD = 8'h96;
    bus.spiOP  = TR;
    @(posedge clk); #1;
    bus.spiOP = NOP;
    rises = 0; prev = 1'b0; got = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (bus.sdCLK && !prev) rises++;
      prev = bus.sdCLK;
      if (rises == 4) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rise4_reached", int'(got), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_sdclk", int'(bus.sdCLK), 0);
    chk("midrst_sddi", int'(bus.sdDI), 1);
    chk("midrst_sdcs", int'(bus.sdCS), 1);
    chk("midrst_busy", int'(bus.spiBUSY), 0);
    chk("midrst_rxd", int'(bus.spiRXD), 0);
    extra = int'(bus.spiDONE);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.spiDONE) extra++;
      if (bus.sdCLK) extra++;
    end
    chk("midrst_no_done_no_clk", extra, 0);

    // speed must be back to slow after reset
    run_vec(mk(TR, 8'h3C, 8'hA5, 0, 1, 1601, 1'b1, 8'hA5, 8, 100));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
